xyolo_read_stage: RTL and testbench
===================================

# xyolo_read_stage

Upstream neighbour of the YOLO write stage: fetches a layer's weight block and biases from external memory over one databus port, stores the weights across `N_VECT` lane memories, then streams weight vectors in lock-step with an internal address generator. Its `flow_out_weight` and `flow_out_bias` connect directly to the write stage's `flow_in_weight` and `flow_in_bias`. Lane 0 occupies the most-significant `DATA_W` slice of every vector, matching the write stage.

## Interface
- `DATA_W`, 32, word width
- `N_VECT`, 16, number of lanes (equals `nYOLOvect`)
- `ADDR_W`, 10, lane memory address width
- `IO_ADDR_W`, 32, external address width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  start pulse, sampled only in IDLE
- `done`  out  1  high when idle and not busy
- `databus_valid`  out  1  read request
- `databus_ready`  in  1  request accepted, `rdata` valid this cycle
- `databus_addr`  out  IO_ADDR_W  word address
- `databus_rdata`  in  DATA_W  read data
- `ext_addr`  in  IO_ADDR_W  base word address of the weight block
- `len`  in  ADDR_W+1  weight words per lane
- `int_start`  in  ADDR_W  first stream address
- `int_iter`  in  ADDR_W  stream iterations
- `int_per`  in  ADDR_W  reads per iteration
- `int_incr`  in  ADDR_W  address step within an iteration
- `int_shift`  in  ADDR_W  base step between iterations
- `flow_out_weight`  out  N_VECT*DATA_W  weight vector
- `flow_out_bias`  out  N_VECT*DATA_W  bias vector, held
- `flow_out_valid`  out  1  `flow_out_weight` valid this cycle

## Operation
- **Configuration capture:** all configuration inputs are captured on the accepted `run` and held until DONE.
- **State machine:** IDLE → LOAD_W → LOAD_B → STREAM → IDLE.
  - `run` outside IDLE is ignored.
- **LOAD_W:** issues `len*N_VECT` reads at `ext_addr+k`, for k = 0 up to `len*N_VECT-1`.
  - Returned word k is written to lane `k % N_VECT` at address `(k / N_VECT) mod 2^ADDR_W`. Addresses wrap; there is no error flag.
  - If `len` = 0, LOAD_W is skipped.
- **LOAD_B:** issues `N_VECT` reads at `ext_addr + len*N_VECT + b`.
  - Word b goes to bias register b.
- **STREAM:** for i = 0 up to `int_iter-1` and j = 0 up to `int_per-1`, reads all lanes at `int_start + i*int_shift + j*int_incr`, one address per cycle with no bubbles.
  - Addresses are computed incrementally and wrap mod 2^ADDR_W.
  - If `int_iter` = 0 or `int_per` = 0, STREAM is skipped.
- **Databus:** while `databus_valid` is high, `databus_addr` is stable.
  - A transfer occurs on a cycle where `valid & ready` are both high.
  - The next address is presented in the following cycle, so back-to-back transfers are allowed.
  - `databus_valid` is low outside LOAD_W and LOAD_B.
- **Bias persistence:** `flow_out_bias` keeps its value until the next LOAD_B or `rst`.

## Timing
- **Reset values:** IDLE; `done`=1, `databus_valid`=0, `databus_addr`=0, `flow_out_valid`=0, `flow_out_weight`=0, `flow_out_bias`=0, all counters 0.
- **Start:** `done` falls the cycle after `run` is accepted. `databus_valid` rises in that same cycle.
- **Read latency:** the lane memory has a 1-cycle read, followed by an output register. The vector for stream index n appears exactly 2 cycles after its address is issued.
  - `flow_out_valid` is high for exactly `int_iter*int_per` consecutive cycles.
- **Completion:** `done` rises the cycle after the last `flow_out_valid`, or the cycle after LOAD_B finishes if STREAM is skipped.
- **Write/read spacing:** the last lane-memory write lands at least 1 cycle before the first STREAM read. No read-during-write hazard exists.
- **Reset mid-operation:** `rst` has priority over every event. On the next edge the block returns to IDLE with `databus_valid`=0.
  - A pending bus transfer is abandoned; the bus side tolerates this.
- **Simultaneous `rst` and `run`:** `rst` wins.

## Configuration
- **`XYOLO_READ_BIAS_EN` defined:** LOAD_B is present and the bias registers are loaded as above.
- **`XYOLO_READ_BIAS_EN` undefined:** LOAD_B and the bias registers are removed; `flow_out_bias` is tied to 0.
  - LOAD_W goes directly to STREAM.
  - External reads total `len*N_VECT`.

## Test plan
- **Basic run:** N_VECT=4, `len`=2, `ext_addr`=0x100, memory holds word=address, `ready` always 1, iter=1, per=2, incr=1, start=0.
  - Exactly 12 transfers, addresses 0x100–0x10B.
  - Bias vector = {0x108,0x109,0x10A,0x10B}.
  - Weight vectors {0x100..0x103} then {0x104..0x107} on 2 consecutive valid cycles, 2 cycles after the STREAM reads begin.
  - `done` high the next cycle.
- **Backpressure:** same as basic, `ready` toggling 1,0,0,1,…
  - Address holds while `ready`=0.
  - Stored contents and outputs are identical to the basic run.
- **Stride wrap:** ADDR_W=3, iter=3, per=2, incr=1, shift=7, start=6.
  - Read addresses 6,7,5,6,4,5.
  - 6 valid cycles.
- **Degenerate:** `len`=0, iter=0.
  - Only the N_VECT bias reads occur; no `flow_out_valid`.
  - `done` rises right after the bias load.
- **Reset mid-load:** `rst` asserted during the 5th transfer.
  - Next cycle: `databus_valid`=0, `done`=1, all outputs 0.
  - A new `run` restarts from `ext_addr`.
- **Macro off:** `XYOLO_READ_BIAS_EN` undefined, basic run.
  - Exactly 8 transfers.
  - `flow_out_bias`=0.

Source files
------------

// File: rtl/xyolo_read_stage.sv
// xyolo_read_stage
//   Fetches one layer's weight block (len words per lane, N_VECT lanes,
//   interleaved lane-fastest in external memory) and N_VECT bias words over
//   a single read-only databus. The weights are spread across N_VECT lane
//   memories. The block then streams weight vectors from those memories
//   using a two-level strided address generator.
//
//   Configuration macro: XYOLO_READ_BIAS_EN
//     defined   -> the bias load phase and the bias registers are present
//     undefined -> no bias phase; flow_out_bias is tied to zero
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   run / done        start pulse (accepted only when idle) / idle flag
//   databus_*         valid/ready read port; rdata is valid in the accept cycle
//   ext_addr, len     base word address of the block, weight words per lane
//   int_start/iter/per/incr/shift
//                     stream address generator:
//                     addr = start + i*shift + j*incr (mod 2^ADDR_W)
//   flow_out_weight   weight vector, lane 0 in the most-significant slice
//   flow_out_bias     bias vector, held until the next bias load or reset
//   flow_out_valid    flow_out_weight carries a new vector this cycle
module xyolo_read_stage #(
  parameter int DATA_W    = 32,
  parameter int N_VECT    = 16,
  parameter int ADDR_W    = 10,
  parameter int IO_ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  output logic                       done,
  output logic                       databus_valid,
  input  logic                       databus_ready,
  output logic [IO_ADDR_W-1:0]       databus_addr,
  input  logic [DATA_W-1:0]          databus_rdata,
  input  logic [IO_ADDR_W-1:0]       ext_addr,
  input  logic [ADDR_W:0]            len,
  input  logic [ADDR_W-1:0]          int_start,
  input  logic [ADDR_W-1:0]          int_iter,
  input  logic [ADDR_W-1:0]          int_per,
  input  logic [ADDR_W-1:0]          int_incr,
  input  logic [ADDR_W-1:0]          int_shift,
  output logic [N_VECT*DATA_W-1:0]   flow_out_weight,
  output logic [N_VECT*DATA_W-1:0]   flow_out_bias,
  output logic                       flow_out_valid
);

  localparam int LANE_W = (N_VECT > 1) ? $clog2(N_VECT) : 1;
  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(N_VECT - 1);
  localparam logic [LANE_W-1:0]    LANE_ONE  = LANE_W'(1);
  localparam logic [ADDR_W:0]      ROW_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0]    A_ONE     = ADDR_W'(1);
  localparam logic [IO_ADDR_W-1:0] IO_ONE    = IO_ADDR_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD_W = 2'd1;
  localparam logic [1:0] S_LOAD_B = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  logic [1:0]           state_reg;
  logic                 bus_valid_reg;
  logic [IO_ADDR_W-1:0] bus_addr_reg;

  // Captured configuration
  logic [ADDR_W:0]      len_reg;
  logic [ADDR_W-1:0]    iter_reg;
  logic [ADDR_W-1:0]    per_reg;
  logic [ADDR_W-1:0]    incr_reg;
  logic [ADDR_W-1:0]    shift_reg;
  logic                 stream_go_reg;   // iter and per both non-zero

  // Load-phase position: lane is the fast index, row the slow one
  logic [LANE_W-1:0]    lane_reg;
  logic [ADDR_W:0]      row_reg;

  // Stream address generator
  logic                 issuing_reg;
  logic [ADDR_W-1:0]    i_reg;
  logic [ADDR_W-1:0]    j_reg;
  logic [ADDR_W-1:0]    base_reg;
  logic [ADDR_W-1:0]    rd_addr_reg;

  // Read pipeline: memory read register, then output register
  logic                 rd_valid_reg;
  logic                 out_valid_reg;

  logic xfer;
  logic last_lane;
  logic w_last;
  logic last_j;
  logic last_i;
  logic wr_en;
  logic rd_en;

  assign xfer      = bus_valid_reg & databus_ready;
  assign last_lane = (lane_reg == LAST_LANE);
  // len_reg is non-zero whenever LOAD_W is entered, so len_reg-1 cannot underflow there
  assign w_last    = last_lane && (row_reg == len_reg - ROW_ONE);
  assign last_j    = (j_reg == per_reg - A_ONE);
  assign last_i    = (i_reg == iter_reg - A_ONE);
  assign wr_en     = xfer && (state_reg == S_LOAD_W);
  assign rd_en     = (state_reg == S_STREAM) && issuing_reg;

  assign done           = (state_reg == S_IDLE);
  assign databus_valid  = bus_valid_reg;
  assign databus_addr   = bus_addr_reg;
  assign flow_out_valid = out_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      bus_valid_reg <= 1'b0;
      bus_addr_reg  <= '0;
      len_reg       <= '0;
      iter_reg      <= '0;
      per_reg       <= '0;
      incr_reg      <= '0;
      shift_reg     <= '0;
      stream_go_reg <= 1'b0;
      lane_reg      <= '0;
      row_reg       <= '0;
      issuing_reg   <= 1'b0;
      i_reg         <= '0;
      j_reg         <= '0;
      base_reg      <= '0;
      rd_addr_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (run) begin
            len_reg       <= len;
            iter_reg      <= int_iter;
            per_reg       <= int_per;
            incr_reg      <= int_incr;
            shift_reg     <= int_shift;
            stream_go_reg <= (int_iter != '0) && (int_per != '0);
            bus_addr_reg  <= ext_addr;
            lane_reg      <= '0;
            row_reg       <= '0;
            i_reg         <= '0;
            j_reg         <= '0;
            base_reg      <= int_start;
            rd_addr_reg   <= int_start;
            if (len != '0) begin
              state_reg     <= S_LOAD_W;
              bus_valid_reg <= 1'b1;
            end else begin
`ifdef XYOLO_READ_BIAS_EN
              state_reg     <= S_LOAD_B;
              bus_valid_reg <= 1'b1;
`else
              // Nothing to fetch: spend at least one cycle out of IDLE so
              // done still drops after the accepted run.
              state_reg     <= S_STREAM;
              issuing_reg   <= (int_iter != '0) && (int_per != '0);
`endif
            end
          end
        end

        S_LOAD_W: begin
          if (xfer) begin
            bus_addr_reg <= bus_addr_reg + IO_ONE;
            if (last_lane) begin
              lane_reg <= '0;
              row_reg  <= row_reg + ROW_ONE;
            end else begin
              lane_reg <= lane_reg + LANE_ONE;
            end
            if (w_last) begin
`ifdef XYOLO_READ_BIAS_EN
              // Bias words follow the weights directly; the bus stays valid.
              state_reg <= S_LOAD_B;
`else
              bus_valid_reg <= 1'b0;
              state_reg     <= stream_go_reg ? S_STREAM : S_IDLE;
              issuing_reg   <= stream_go_reg;
`endif
            end
          end
        end

        S_LOAD_B: begin
          if (xfer) begin
            bus_addr_reg <= bus_addr_reg + IO_ONE;
            lane_reg     <= last_lane ? '0 : lane_reg + LANE_ONE;
            if (last_lane) begin
              bus_valid_reg <= 1'b0;
              state_reg     <= stream_go_reg ? S_STREAM : S_IDLE;
              issuing_reg   <= stream_go_reg;
            end
          end
        end

        default: begin // S_STREAM
          if (issuing_reg) begin
            if (last_j) begin
              j_reg       <= '0;
              i_reg       <= i_reg + A_ONE;
              base_reg    <= base_reg + shift_reg;
              rd_addr_reg <= base_reg + shift_reg;
              if (last_i) begin
                issuing_reg <= 1'b0;
              end
            end else begin
              j_reg       <= j_reg + A_ONE;
              rd_addr_reg <= rd_addr_reg + incr_reg;
            end
          end else if (!rd_valid_reg) begin
            // The last read has left the memory stage; its vector is in the
            // output register this cycle, so idle begins right after it.
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg  <= rd_en;
      out_valid_reg <= rd_valid_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_VECT; gi++) begin : g_lane
      logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
      logic [DATA_W-1:0] rd_data_reg;
      logic [DATA_W-1:0] out_reg;

      // Plain synchronous RAM: write port from the load phase, registered read
      always_ff @(posedge clk) begin
        if (wr_en && (lane_reg == LANE_W'(gi))) begin
          mem[row_reg[ADDR_W-1:0]] <= databus_rdata;
        end
        if (rd_en) begin
          rd_data_reg <= mem[rd_addr_reg];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          out_reg <= '0;
        end else if (rd_valid_reg) begin
          out_reg <= rd_data_reg;
        end
      end

      assign flow_out_weight[(N_VECT-1-gi)*DATA_W +: DATA_W] = out_reg;

`ifdef XYOLO_READ_BIAS_EN
      logic [DATA_W-1:0] bias_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          bias_reg <= '0;
        end else if (xfer && (state_reg == S_LOAD_B) && (lane_reg == LANE_W'(gi))) begin
          bias_reg <= databus_rdata;
        end
      end

      assign flow_out_bias[(N_VECT-1-gi)*DATA_W +: DATA_W] = bias_reg;
`else
      assign flow_out_bias[(N_VECT-1-gi)*DATA_W +: DATA_W] = '0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_xyolo_read_stage.sv
module tb_xyolo_read_stage;

  localparam int DW = 32;
  localparam int NV = 4;
  localparam int AW = 3;
  localparam int IW = 32;

`ifdef XYOLO_READ_BIAS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              done;
  logic              databus_valid;
  logic              databus_ready;
  logic [IW-1:0]     databus_addr;
  logic [DW-1:0]     databus_rdata;
  logic [IW-1:0]     ext_addr;
  logic [AW:0]       len;
  logic [AW-1:0]     int_start;
  logic [AW-1:0]     int_iter;
  logic [AW-1:0]     int_per;
  logic [AW-1:0]     int_incr;
  logic [AW-1:0]     int_shift;
  logic [NV*DW-1:0]  flow_out_weight;
  logic [NV*DW-1:0]  flow_out_bias;
  logic              flow_out_valid;

  always #5 clk = ~clk;

  // External memory: every word holds its own address
  assign databus_rdata = databus_addr;

  xyolo_read_stage #(
    .DATA_W(DW), .N_VECT(NV), .ADDR_W(AW), .IO_ADDR_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .done(done),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_rdata(databus_rdata),
    .ext_addr(ext_addr), .len(len), .int_start(int_start),
    .int_iter(int_iter), .int_per(int_per), .int_incr(int_incr),
    .int_shift(int_shift), .flow_out_weight(flow_out_weight),
    .flow_out_bias(flow_out_bias), .flow_out_valid(flow_out_valid)
  );

  typedef struct {
    logic [31:0]  ext;
    logic [3:0]   ln;
    logic [2:0]   start, iter, per, incr, shift;
    int           rmode;       // 0: ready always 1, 1: ready pattern 1,0,0
    int           extra_run;   // cycle at which a stray run is pulsed (0 = none)
    int           exp_xfers;
    int           exp_nvalid;
    int           exp_first_v;
    int           exp_done;
    int           exp_rows[6];
    logic [127:0] exp_bias;
  } vec_t;

  vec_t tbl[4];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_vec(input logic [31:0] ext, input int row);
    logic [127:0] v;
    v = '0;
    for (int l = 0; l < NV; l++) v[(NV-1-l)*DW +: DW] = ext + 32'(NV*row + l);
    return v;
  endfunction

  task automatic do_run(input int idx);
    vec_t v;
    int cyc, nx, nv, first_v, last_v, done_cyc, exp_last;
    logic pv, pr;
    logic [31:0] pa;
    bit fin;
    v = tbl[idx];
    @(negedge clk);
    ext_addr = v.ext; len = v.ln; int_start = v.start; int_iter = v.iter;
    int_per = v.per; int_incr = v.incr; int_shift = v.shift; run = 1'b1;
    cyc = 0; nx = 0; nv = 0; first_v = 0; last_v = 0; done_cyc = 0;
    pv = 1'b0; pr = 1'b0; pa = '0; fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      run = (cyc == v.extra_run);
      if (cyc == 1) begin
        chk("done_fall", {127'b0, done}, 128'd0);
        // Inputs change after capture; the run must not notice
        ext_addr = 32'hDEAD0000; len = 4'hF; int_start = 3'd3;
        int_iter = 3'd7; int_per = 3'd7; int_incr = 3'd2; int_shift = 3'd1;
      end
      databus_ready = (v.rmode == 0) ? 1'b1 : (((cyc - 1) % 3) == 0);
      if (databus_valid) begin
        if (pv && !pr) chk("addr_hold", {96'b0, databus_addr}, {96'b0, pa});
        if (databus_ready) begin
          chk("xfer_addr", {96'b0, databus_addr}, {96'b0, v.ext + 32'(nx)});
          nx++;
        end
      end
      pv = databus_valid; pr = databus_ready; pa = databus_addr;
      if (flow_out_valid) begin
        if (nv == 0) first_v = cyc;
        last_v = cyc;
        if (nv < v.exp_nvalid) chk("weight", flow_out_weight, exp_vec(v.ext, v.exp_rows[nv]));
        nv++;
      end
      if (done && cyc > 1) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (cyc >= 400) begin
        n_checks++;
        n_fail++;
        $display("FAIL timeout: run %0d not done after %0d cycles", idx, cyc);
        fin = 1'b1;
      end
    end
    databus_ready = 1'b0;
    run = 1'b0;
    exp_last = (v.exp_nvalid > 0) ? v.exp_first_v + v.exp_nvalid - 1 : 0;
    chk("xfer_count",  128'(nx),       128'(v.exp_xfers));
    chk("valid_count", 128'(nv),       128'(v.exp_nvalid));
    chk("first_valid", 128'(first_v),  128'(v.exp_first_v));
    chk("last_valid",  128'(last_v),   128'(exp_last));
    chk("done_cycle",  128'(done_cyc), 128'(v.exp_done));
    chk("bias",        flow_out_bias,  v.exp_bias);
    $display("run %0d: ext=%h xfers=%0d valids=%0d first_valid=%0d done_cycle=%0d",
             idx, v.ext, nx, nv, first_v, done_cyc);
  endtask

  initial begin
    int xk;
    // basic
    tbl[0] = '{ext:32'h100, ln:4'd2, start:3'd0, iter:3'd1, per:3'd2, incr:3'd1, shift:3'd0,
               rmode:0, extra_run:0, exp_xfers:8+4*B, exp_nvalid:2, exp_first_v:11+4*B,
               exp_done:13+4*B, exp_rows:'{0,1,0,0,0,0},
               exp_bias:(B != 0) ? {32'h108, 32'h109, 32'h10A, 32'h10B} : 128'h0};
    // backpressure, plus a stray run during the load
    tbl[1] = '{ext:32'h100, ln:4'd2, start:3'd0, iter:3'd1, per:3'd2, incr:3'd1, shift:3'd0,
               rmode:1, extra_run:5, exp_xfers:8+4*B, exp_nvalid:2, exp_first_v:25+12*B,
               exp_done:27+12*B, exp_rows:'{0,1,0,0,0,0},
               exp_bias:(B != 0) ? {32'h108, 32'h109, 32'h10A, 32'h10B} : 128'h0};
    // stride wrap: rows 6,7,5,6,4,5
    tbl[2] = '{ext:32'h200, ln:4'd8, start:3'd6, iter:3'd3, per:3'd2, incr:3'd1, shift:3'd7,
               rmode:0, extra_run:0, exp_xfers:32+4*B, exp_nvalid:6, exp_first_v:35+4*B,
               exp_done:41+4*B, exp_rows:'{6,7,5,6,4,5},
               exp_bias:(B != 0) ? {32'h220, 32'h221, 32'h222, 32'h223} : 128'h0};
    // degenerate: len=0, iter=0
    tbl[3] = '{ext:32'h300, ln:4'd0, start:3'd0, iter:3'd0, per:3'd2, incr:3'd1, shift:3'd0,
               rmode:0, extra_run:0, exp_xfers:4*B, exp_nvalid:0, exp_first_v:0,
               exp_done:2+3*B, exp_rows:'{0,0,0,0,0,0},
               exp_bias:(B != 0) ? {32'h300, 32'h301, 32'h302, 32'h303} : 128'h0};

    rst = 1'b1; run = 1'b0; databus_ready = 1'b0;
    ext_addr = '0; len = '0; int_start = '0; int_iter = '0;
    int_per = '0; int_incr = '0; int_shift = '0;
    repeat (3) @(negedge clk);
    chk("rst_done",   {127'b0, done},           128'd1);
    chk("rst_valid",  {127'b0, databus_valid},  128'd0);
    chk("rst_addr",   {96'b0, databus_addr},    128'd0);
    chk("rst_fvalid", {127'b0, flow_out_valid}, 128'd0);
    chk("rst_weight", flow_out_weight,          128'd0);
    chk("rst_bias",   flow_out_bias,            128'd0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) do_run(t);

    // Reset asserted in the cycle of the 5th transfer
    @(negedge clk);
    ext_addr = 32'h100; len = 4'd2; int_start = 3'd0; int_iter = 3'd1;
    int_per = 3'd2; int_incr = 3'd1; int_shift = 3'd0; run = 1'b1;
    xk = 0;
    for (int c = 0; c < 50 && xk < 5; c++) begin
      @(negedge clk);
      run = 1'b0;
      databus_ready = 1'b1;
      if (databus_valid) xk++;
    end
    chk("mid_xfers", 128'(xk), 128'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    databus_ready = 1'b0;
    chk("mid_valid",  {127'b0, databus_valid},  128'd0);
    chk("mid_done",   {127'b0, done},           128'd1);
    chk("mid_addr",   {96'b0, databus_addr},    128'd0);
    chk("mid_fvalid", {127'b0, flow_out_valid}, 128'd0);
    chk("mid_weight", flow_out_weight,          128'd0);
    chk("mid_bias",   flow_out_bias,            128'd0);
    $display("reset mid-load after %0d transfers", xk);

    // Fresh run after the abandoned load restarts from ext_addr
    do_run(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
